hazard_unit: RTL and testbench

- Pipeline hazard and forwarding controller for the 5-stage core (IF, ID, EX, MEM, WB) running the 19-bit ISA.
- Keeps a shadow scoreboard of destination registers for the instructions in EX, MEM and WB.
- Detects load-use stalls and redirect flushes, and issues registered forwarding selects for the ALU operand muxes.
- Sits beside the instruction decoder; the decoder and this block both take the ID-stage instruction.

---
 rtl/hazard_unit_if.sv | 58 +++++
 rtl/hazard_unit.sv | 205 ++++++++++++++++++++
 tb/tb_hazard_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - pipeline-side bundle for the hazard and forwarding controller
//
// Purpose: groups the ID-stage inputs and the stall/flush/forward outputs of
// hazard_unit so the core and the controller connect through one port.
//
// Signals:
//   id_instruction  19     instruction currently in ID
//   id_valid        1      ID holds a real instruction (0 = bubble)
//   ex_branch_taken 1      branch resolved taken in EX this cycle
//   stall           1      hold PC and IF/ID register
//   bubble_ex       1      load NOP into ID/EX this cycle
//   flush_ifid      1      kill IF/ID contents this cycle
//   fwd_a, fwd_b    2      EX operand selects: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   stall_count     CNT_W  saturating count of stall cycles
//   flush_count     CNT_W  saturating count of flush events
//
// Modports: master = pipeline side, slave = hazard_unit.

interface hazard_unit_if #(
  parameter int CNT_W = 16
);
  logic [18:0]      id_instruction;
  logic             id_valid;
  logic             ex_branch_taken;
  logic             stall;
  logic             bubble_ex;
  logic             flush_ifid;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_instruction,
    output id_valid,
    output ex_branch_taken,
    input  stall,
    input  bubble_ex,
    input  flush_ifid,
    input  fwd_a,
    input  fwd_b,
    input  stall_count,
    input  flush_count
  );

  modport slave (
    input  id_instruction,
    input  id_valid,
    input  ex_branch_taken,
    output stall,
    output bubble_ex,
    output flush_ifid,
    output fwd_a,
    output fwd_b,
    output stall_count,
    output flush_count
  );
endinterface

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use stall, redirect flush and operand forwarding control
//
// Purpose: decodes the ID-stage instruction, tracks the destination registers
// of the instructions in EX, MEM and WB in a shadow scoreboard, raises
// stall/bubble/flush controls and registers the ALU operand forwarding selects
// so they are valid during the consumer's EX cycle.
//
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous, active-low reset
//   hz     hazard_unit_if.slave (ID instruction in; stall/bubble/flush,
//          forwarding selects and performance counters out)

module hazard_unit #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  hazard_unit_if.slave hz
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             we;
    logic             load;
  } slot_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXM = 2'b01;
  localparam logic [1:0] FWD_MWB = 2'b10;

  // ---------------------------------------------------------------------------
  // ID-stage decode
  // ---------------------------------------------------------------------------
  logic [18:0]      instr;
  logic [REG_W-1:0] dec_rd;
  logic [REG_W-1:0] dec_rs;
  logic [REG_W-1:0] dec_src_b;
  logic             dec_use_a;
  logic             dec_use_b;
  logic             dec_we;
  logic             dec_load;
  logic             dec_jump;

  assign instr = hz.id_instruction;

  always_comb begin
    dec_rd    = instr[11 +: REG_W];
    dec_rs    = instr[8 +: REG_W];
    dec_src_b = instr[5 +: REG_W];
    dec_use_a = 1'b0;
    dec_use_b = 1'b0;
    dec_we    = 1'b0;
    dec_load  = 1'b0;
    dec_jump  = 1'b0;

    if (!instr[18]) begin
      // ALU register form reads rt as well; immediate form only rs.
      dec_use_a = 1'b1;
      dec_use_b = ~instr[17];
      dec_we    = 1'b1;
    end else begin
      unique case (instr[17:16])
        2'b00: begin
          dec_use_a = 1'b1;
          if (instr[14]) begin
            // STM: store data comes from the rd field and travels on operand B.
            dec_use_b = 1'b1;
            dec_src_b = instr[11 +: REG_W];
          end else begin
            dec_we   = 1'b1;
            dec_load = 1'b1;
          end
        end
        2'b10: begin
          dec_use_a = 1'b1;
          dec_we    = 1'b1;
        end
        2'b11: begin
          // 1110? is JMP/JSB, 11110 is RET.
          dec_jump = ~instr[15] | (instr[15:14] == 2'b10);
        end
        default: begin
          // Branch: resolved in EX, touches no registers here.
        end
      endcase
    end

    // A bubble in ID reads, writes and redirects nothing.
    if (!hz.id_valid) begin
      dec_use_a = 1'b0;
      dec_use_b = 1'b0;
      dec_we    = 1'b0;
      dec_load  = 1'b0;
      dec_jump  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard and forwarding
  // ---------------------------------------------------------------------------
  slot_t ex_q, ex_d;
  slot_t mem_q, mem_d;
  slot_t wb_q, wb_d;

  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  function automatic logic slot_hit(input slot_t s, input logic [REG_W-1:0] src);
    return s.valid && s.we && (s.rd != '0) && (s.rd == src);
  endfunction

  // WB matches fall back to the regfile: it is written before it is read.
  function automatic logic [1:0] fwd_sel(input logic use_src,
                                         input logic [REG_W-1:0] src,
                                         input slot_t ex_s,
                                         input slot_t mem_s,
                                         input slot_t wb_s);
    logic [1:0] sel;
    sel = FWD_RF;
    if (!use_src)                sel = FWD_RF;
    else if (slot_hit(ex_s, src))  sel = FWD_EXM;
    else if (slot_hit(mem_s, src)) sel = FWD_MWB;
    else if (slot_hit(wb_s, src))  sel = FWD_RF;
    return sel;
  endfunction

  logic load_use;
  logic stall_int;
  logic bubble_int;
  logic flush_int;

  always_comb begin
    load_use = ex_q.valid && ex_q.load && ex_q.we && (ex_q.rd != '0) &&
               ((dec_use_a && (ex_q.rd == dec_rs)) ||
                (dec_use_b && (ex_q.rd == dec_src_b)));

    // A taken branch kills the ID instruction, so any stall it would cause is moot.
    stall_int  = load_use && !hz.ex_branch_taken;
    bubble_int = load_use || hz.ex_branch_taken;
    flush_int  = hz.ex_branch_taken || (dec_jump && !load_use);
  end

  always_comb begin
    ex_d  = '0;
    mem_d = ex_q;
    wb_d  = mem_q;
    if (!bubble_int && hz.id_valid) begin
      ex_d.valid = 1'b1;
      ex_d.rd    = dec_rd;
      ex_d.we    = dec_we;
      ex_d.load  = dec_load;
    end

    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (!bubble_int) begin
      fwd_a_d = fwd_sel(dec_use_a, dec_rs,    ex_q, mem_q, wb_q);
      fwd_b_d = fwd_sel(dec_use_b, dec_src_b, ex_q, mem_q, wb_q);
    end

    stall_count_d = stall_count_q;
    if (stall_int && (stall_count_q != '1)) stall_count_d = stall_count_q + 1'b1;

    flush_count_d = flush_count_q;
    if (flush_int && (flush_count_q != '1)) flush_count_d = flush_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      fwd_a_q       <= FWD_RF;
      fwd_b_q       <= FWD_RF;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      fwd_a_q       <= fwd_a_d;
      fwd_b_q       <= fwd_b_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  // Gate the combinational controls so an asynchronous reset silences them at once.
  assign hz.stall       = reset & stall_int;
  assign hz.bubble_ex   = reset & bubble_int;
  assign hz.flush_ifid  = reset & flush_int;
  assign hz.fwd_a       = fwd_a_q;
  assign hz.fwd_b       = fwd_b_q;
  assign hz.stall_count = stall_count_q;
  assign hz.flush_count = flush_count_q;

  logic unused_bits;
  assign unused_bits = ^{instr[4:0], wb_q.load};

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed self-checking bench for hazard_unit

module tb_hazard_unit;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  hazard_unit_if #(.CNT_W(16)) hz ();

  hazard_unit #(.REG_W(3), .CNT_W(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] enc_alu(input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt);
    return {2'b00, 3'b000, rd, rs, rt, 5'b00000};
  endfunction

  function automatic logic [18:0] enc_ldm(input logic [2:0] rd, input logic [2:0] rs);
    return {3'b100, 2'b00, rd, rs, 8'h00};
  endfunction

  function automatic logic [18:0] enc_stm(input logic [2:0] data, input logic [2:0] rs);
    return {3'b100, 2'b01, data, rs, 8'h00};
  endfunction

  localparam logic [18:0] JMP = {4'b1110, 15'd0};

  // Present one ID-stage slot just after an edge; returns with outputs settled.
  task automatic drive(input logic [18:0] ins, input logic v, input logic br);
    @(posedge clk);
    #1;
    hz.id_instruction  = ins;
    hz.id_valid        = v;
    hz.ex_branch_taken = br;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(19'd0, 1'b0, 1'b0);
  endtask

  initial begin
    reset              = 1'b0;
    hz.id_instruction  = 19'd0;
    hz.id_valid        = 1'b0;
    hz.ex_branch_taken = 1'b0;

    #12;
    check("rst_fwd_a", hz.fwd_a, 0);
    check("rst_fwd_b", hz.fwd_b, 0);
    check("rst_stall_cnt", hz.stall_count, 0);
    check("rst_flush_cnt", hz.flush_count, 0);
    hz.ex_branch_taken = 1'b1;
    #1;
    check("rst_flush_gated", hz.flush_ifid, 0);
    check("rst_bubble_gated", hz.bubble_ex, 0);
    check("rst_stall", hz.stall, 0);
    hz.ex_branch_taken = 1'b0;
    #5;
    reset = 1'b1;
    idle(2);

    // Back-to-back ALU dependency: EX/MEM forwarding on both operands.
    drive(enc_alu(3'd1, 3'd2, 3'd3), 1'b1, 1'b0);
    check("t1_stall0", hz.stall, 0);
    drive(enc_alu(3'd4, 3'd1, 3'd1), 1'b1, 1'b0);
    check("t1_stall1", hz.stall, 0);
    drive(19'd0, 1'b0, 1'b0);
    check("t1_fwd_a", hz.fwd_a, 2'b01);
    check("t1_fwd_b", hz.fwd_b, 2'b01);

    // Load-use: one stall cycle, then MEM/WB forwarding.
    idle(3);
    drive(enc_ldm(3'd2, 3'd5), 1'b1, 1'b0);
    check("t2_ld_stall", hz.stall, 0);
    drive(enc_alu(3'd3, 3'd2, 3'd6), 1'b1, 1'b0);
    check("t2_stall", hz.stall, 1);
    check("t2_bubble", hz.bubble_ex, 1);
    check("t2_flush", hz.flush_ifid, 0);
    drive(enc_alu(3'd3, 3'd2, 3'd6), 1'b1, 1'b0);
    check("t2_stall_gone", hz.stall, 0);
    check("t2_bubble_gone", hz.bubble_ex, 0);
    drive(19'd0, 1'b0, 1'b0);
    check("t2_fwd_a", hz.fwd_a, 2'b10);
    check("t2_fwd_b", hz.fwd_b, 2'b00);
    check("t2_stall_cnt", hz.stall_count, 1);

    // Distance two: MEM/WB forwarding. Distance three: regfile.
    idle(3);
    drive(enc_alu(3'd1, 3'd2, 3'd3), 1'b1, 1'b0);
    drive(19'd0, 1'b0, 1'b0);
    drive(enc_alu(3'd7, 3'd1, 3'd1), 1'b1, 1'b0);
    drive(19'd0, 1'b0, 1'b0);
    check("t3_fwd_a", hz.fwd_a, 2'b10);
    check("t3_fwd_b", hz.fwd_b, 2'b10);
    drive(enc_alu(3'd1, 3'd2, 3'd3), 1'b1, 1'b0);
    drive(19'd0, 1'b0, 1'b0);
    drive(19'd0, 1'b0, 1'b0);
    drive(enc_alu(3'd2, 3'd1, 3'd1), 1'b1, 1'b0);
    drive(19'd0, 1'b0, 1'b0);
    check("t3_wb_fwd_a", hz.fwd_a, 2'b00);
    check("t3_wb_fwd_b", hz.fwd_b, 2'b00);

    // Destination R0 never forwards nor stalls.
    idle(3);
    drive(enc_alu(3'd0, 3'd2, 3'd3), 1'b1, 1'b0);
    drive(enc_alu(3'd4, 3'd0, 3'd0), 1'b1, 1'b0);
    check("t4_stall", hz.stall, 0);
    drive(enc_ldm(3'd0, 3'd5), 1'b1, 1'b0);
    check("t4_fwd_a", hz.fwd_a, 2'b00);
    check("t4_fwd_b", hz.fwd_b, 2'b00);
    drive(enc_alu(3'd4, 3'd0, 3'd0), 1'b1, 1'b0);
    check("t4_ld_r0_stall", hz.stall, 0);

    // STM data register is operand B.
    idle(3);
    drive(enc_alu(3'd5, 3'd1, 3'd2), 1'b1, 1'b0);
    drive(enc_stm(3'd5, 3'd3), 1'b1, 1'b0);
    drive(19'd0, 1'b0, 1'b0);
    check("t5_stm_fwd_a", hz.fwd_a, 2'b00);
    check("t5_stm_fwd_b", hz.fwd_b, 2'b01);

    // Taken branch overrides a load-use stall; jump flushes for one cycle.
    idle(3);
    drive(enc_ldm(3'd2, 3'd5), 1'b1, 1'b0);
    drive(enc_alu(3'd3, 3'd2, 3'd6), 1'b1, 1'b1);
    check("t6_stall", hz.stall, 0);
    check("t6_flush", hz.flush_ifid, 1);
    check("t6_bubble", hz.bubble_ex, 1);
    drive(JMP, 1'b1, 1'b0);
    check("t6_flush_cnt", hz.flush_count, 1);
    check("t6_jmp_flush", hz.flush_ifid, 1);
    check("t6_jmp_stall", hz.stall, 0);
    check("t6_jmp_bubble", hz.bubble_ex, 0);
    check("t6_bubble_fwd", hz.fwd_a, 2'b00);
    drive(19'd0, 1'b0, 1'b0);
    check("t6_flush_off", hz.flush_ifid, 0);
    check("t6_flush_cnt2", hz.flush_count, 2);
    check("t6_stall_cnt", hz.stall_count, 1);

    // Asynchronous reset in the middle of a load-use stall.
    idle(3);
    drive(enc_ldm(3'd2, 3'd5), 1'b1, 1'b0);
    drive(enc_alu(3'd3, 3'd2, 3'd6), 1'b1, 1'b0);
    check("t7_pre_stall", hz.stall, 1);
    #1;
    reset = 1'b0;
    #1;
    check("t7_stall", hz.stall, 0);
    check("t7_bubble", hz.bubble_ex, 0);
    check("t7_flush", hz.flush_ifid, 0);
    check("t7_stall_cnt", hz.stall_count, 0);
    check("t7_flush_cnt", hz.flush_count, 0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    drive(enc_alu(3'd3, 3'd2, 3'd6), 1'b1, 1'b0);
    check("t7_held_stall", hz.stall, 0);
    drive(enc_alu(3'd4, 3'd5, 3'd6), 1'b1, 1'b0);
    check("t7_post_stall", hz.stall, 0);
    check("t7_post_cnt", hz.stall_count, 0);
    check("t7_post_fwd_a", hz.fwd_a, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
